// File: rtl/multi_tick_gen_if.sv
// Configuration bus for multi_tick_gen: divisor write port plus the sticky
// bad-channel error flag returned to the register block.
interface multi_tick_gen_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic            cfg_wr;
    logic [CH_W-1:0] cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic            cfg_err;

    modport master (
        output cfg_wr,
        output cfg_ch,
        output cfg_div,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr,
        input  cfg_ch,
        input  cfg_div,
        output cfg_err
    );
endinterface

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator with per-channel wrapping tick counts.
// Define MULTI_TICK_GEN_CYCLE_CNT_EN to build the cycle counters; otherwise cycle reads 0.
module multi_tick_gen #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       ch_en,
    input  logic                      restart,
    multi_tick_gen_if.slave           cfg,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS*WIDTH-1:0] cycle
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [WIDTH-1:0]    div_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [CHANNELS-1:0] tick_q;
    logic                cfg_err_q;

    logic [CHANNELS-1:0] wr_hit;
    logic                wr_bad;
    logic [CHANNELS-1:0] adv;
    logic [CHANNELS-1:0] wrap;

    // Decoding by enumeration keeps out-of-range indices harmless when CHANNELS
    // is not a power of two.
    always_comb begin
        wr_hit = '0;
        adv    = '0;
        wrap   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_hit[c] = cfg.cfg_wr && (cfg.cfg_ch == CH_W'(c));
            adv[c]    = en && ch_en[c] && (div_q[c] != '0);
            wrap[c]   = adv[c] && (cnt_q[c] == div_q[c] - WIDTH'(1));
        end
        wr_bad = cfg.cfg_wr && (wr_hit == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
            tick_q    <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                div_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else if (restart) begin
            tick_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            if (wr_bad) begin
                cfg_err_q <= 1'b1;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_hit[c]) begin
                    div_q[c]  <= cfg.cfg_div;
                    cnt_q[c]  <= '0;
                    tick_q[c] <= 1'b0;
                end else if (adv[c]) begin
                    cnt_q[c]  <= wrap[c] ? '0 : cnt_q[c] + WIDTH'(1);
                    tick_q[c] <= wrap[c];
                end else begin
                    tick_q[c] <= 1'b0;
                end
            end
        end
    end

    assign tick        = tick_q;
    assign cfg.cfg_err = cfg_err_q;

`ifdef MULTI_TICK_GEN_CYCLE_CNT_EN
    logic [WIDTH-1:0] cyc_q [CHANNELS];

    // Tick counts survive restart and divisor writes; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cyc_q[c] <= '0;
            end
        end else if (!restart) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!wr_hit[c] && wrap[c]) begin
                    cyc_q[c] <= cyc_q[c] + WIDTH'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cycle
        assign cycle[c*WIDTH +: WIDTH] = cyc_q[c];
    end
`else
    assign cycle = '0;
`endif

endmodule

// File: tb/tb_multi_tick_gen.sv
// Self-checking bench for multi_tick_gen: directed scenarios with literal
// expectations plus randomized traffic against a progress-count reference model.
module tb_multi_tick_gen;
    localparam int NCH = 5;
    localparam int W   = 8;
    localparam int CHW = 3;

`ifdef MULTI_TICK_GEN_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [NCH-1:0]   ch_en = '0;
    logic             restart = 1'b0;
    logic [NCH-1:0]   tick;
    logic [NCH*W-1:0] cycle;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    multi_tick_gen_if #(.WIDTH(W), .CHANNELS(NCH)) bus ();

    multi_tick_gen #(.WIDTH(W), .CHANNELS(NCH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ch_en   (ch_en),
        .restart (restart),
        .cfg     (bus),
        .tick    (tick),
        .cycle   (cycle)
    );

    always #5 clk = ~clk;

    // Reference: count enabled cycles since the last re-phase; a tick falls on
    // every multiple of the divisor.
    int m_div   [NCH];
    int m_prog  [NCH];
    int m_ticks [NCH];
    bit m_tick  [NCH];
    bit m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_err = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = 0; m_prog[c] = 0; m_ticks[c] = 0; m_tick[c] = 1'b0;
            end
        end else if (restart) begin
            for (int c = 0; c < NCH; c++) begin
                m_prog[c] = 0; m_tick[c] = 1'b0;
            end
        end else begin
            if (bus.cfg_wr && int'(bus.cfg_ch) >= NCH) m_err = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (bus.cfg_wr && int'(bus.cfg_ch) == c) begin
                    m_div[c] = int'(bus.cfg_div); m_prog[c] = 0; m_tick[c] = 1'b0;
                end else if (en && ch_en[c] && m_div[c] != 0) begin
                    m_prog[c] = m_prog[c] + 1;
                    m_tick[c] = (m_prog[c] % m_div[c]) == 0;
                    if (m_tick[c]) m_ticks[c] = (m_ticks[c] + 1) % (1 << W);
                end else begin
                    m_tick[c] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [NCH-1:0]   et;
        logic [NCH*W-1:0] ec;
        if (chk_on) begin
            for (int c = 0; c < NCH; c++) begin
                et[c] = m_tick[c];
                ec[c*W +: W] = CYC_EN ? W'(m_ticks[c]) : '0;
            end
            checkOutput("model_tick", 64'(tick), 64'(et));
            checkOutput("model_cycle", 64'(cycle), 64'(ec));
            checkOutput("model_cfg_err", 64'(bus.cfg_err), 64'(m_err));
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [NCH-1:0] ce,
                                 input logic rs, input logic wr, input logic [CHW-1:0] ch,
                                 input logic [W-1:0] dv);
        rst = r; en = e; ch_en = ce; restart = rs;
        bus.cfg_wr = wr; bus.cfg_ch = ch; bus.cfg_div = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, '1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic writeDiv(input logic [CHW-1:0] ch, input logic [W-1:0] dv);
        applyStimulus(1'b0, 1'b1, '1, 1'b0, 1'b1, ch, dv);
    endtask

    initial begin
        bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk_on = 1'b1;
        checkOutput("reset_tick", 64'(tick), 64'd0);
        checkOutput("reset_cycle", 64'(cycle), 64'd0);
        checkOutput("reset_cfg_err", 64'(bus.cfg_err), 64'd0);

        // div=4 on ch0: ticks 4, 8, 12 edges after the write
        writeDiv(3'd0, 8'd4);
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            checkOutput($sformatf("div4_tick0_%0d", i), 64'(tick[0]), 64'((i % 4) == 0));
            checkOutput($sformatf("div4_others_%0d", i), 64'(tick[NCH-1:1]), 64'd0);
        end
        checkOutput("div4_cycle0", 64'(cycle[W-1:0]), CYC_EN ? 64'd3 : 64'd0);

        // div=1 on ch1, div=3 on ch2, coincident ticks on multiples of 3
        writeDiv(3'd1, 8'd1);
        writeDiv(3'd2, 8'd3);
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            checkOutput($sformatf("div1_tick1_%0d", i), 64'(tick[1]), 64'd1);
            checkOutput($sformatf("div3_tick2_%0d", i), 64'(tick[2]), 64'((i % 3) == 0));
        end

        // div=5 on ch4, freeze at cnt=2 for 7 cycles, phase must resume
        writeDiv(3'd4, 8'd5);
        idle(2);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 5'b01111, 1'b0, 1'b0, '0, '0);
            checkOutput($sformatf("freeze_tick4_%0d", i), 64'(tick[4]), 64'd0);
        end
        for (int i = 1; i <= 8; i++) begin
            idle(1);
            checkOutput($sformatf("resume_tick4_%0d", i), 64'(tick[4]), 64'(i == 3 || i == 8));
        end

        // restart beats a coincident write to ch3 and a pending ch0 tick
        writeDiv(3'd3, 8'd2);
        writeDiv(3'd0, 8'd2);
        idle(1);
        checkOutput("pre_restart_tick3", 64'(tick[3]), 64'd1);
        applyStimulus(1'b0, 1'b1, '1, 1'b1, 1'b1, 3'd3, 8'd7);
        checkOutput("restart_ticks", 64'(tick), 64'd0);
        idle(1);
        checkOutput("restart_e1_tick0", 64'(tick[0]), 64'd0);
        checkOutput("restart_e1_tick3", 64'(tick[3]), 64'd0);
        idle(1);
        checkOutput("restart_e2_tick0", 64'(tick[0]), 64'd1);
        checkOutput("restart_e2_tick3", 64'(tick[3]), 64'd1);

        // out-of-range channel write sets sticky error until reset
        writeDiv(3'd5, 8'd9);
        checkOutput("bad_ch_err", 64'(bus.cfg_err), 64'd1);
        idle(3);
        applyStimulus(1'b0, 1'b1, '1, 1'b1, 1'b0, '0, '0);
        checkOutput("bad_ch_err_sticky", 64'(bus.cfg_err), 64'd1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("bad_ch_err_cleared", 64'(bus.cfg_err), 64'd0);

        // cycle counter wrap on a div=1 channel
        writeDiv(3'd1, 8'd1);
        idle(255);
        checkOutput("wrap_cycle1_255", 64'(cycle[2*W-1:W]), CYC_EN ? 64'd255 : 64'd0);
        idle(1);
        checkOutput("wrap_cycle1_0", 64'(cycle[2*W-1:W]), 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, e, rs, wr;
            logic [NCH-1:0] ce;
            logic [CHW-1:0] ch;
            logic [W-1:0] dv;
            r  = ($urandom_range(0, 499) == 0);
            e  = ($urandom_range(0, 9) != 0);
            ce = NCH'($urandom);
            rs = ($urandom_range(0, 59) == 0);
            wr = ($urandom_range(0, 9) == 0);
            ch = CHW'($urandom);
            dv = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 9));
            applyStimulus(r, e, ce, rs, wr, ch, dv);
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
